// File: rtl/noc_link_credit_rx.sv
// Receive-side terminator for a credit-based NoC link.
// Flits from the upstream router land in a small circular FIFO and are
// presented on a valid/ready stream. Every dequeued flit returns one
// credit upstream. Flits that arrive while the buffer is full, with no pop
// in the same cycle, are dropped and flagged in a sticky error bit.
//
// Output handshake: a transfer happens in any cycle where
// out_valid && out_ready are both high. out_valid never depends on
// out_ready. The head fields (out_data, out_dest, out_last) hold steady
// while out_valid is high and out_ready is low. out_ready is ignored
// while out_valid is low.
module noc_link_credit_rx #(
  parameter int FLIT_WIDTH   = 128,
  parameter int DEST_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 2,
  parameter int CREDIT_REG   = 1
) (
  input  logic                                clk_noc,
  input  logic                                rst_n,
  input  logic [FLIT_WIDTH-1:0]               data_in,
  input  logic [DEST_WIDTH-1:0]               dest_in,
  input  logic                                is_tail_in,
  input  logic                                send_in,
  output logic                                credit_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [FLIT_WIDTH-1:0]               out_data,
  output logic [DEST_WIDTH-1:0]               out_dest,
  output logic                                out_last,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   occupancy,
  output logic                                in_packet,
  output logic                                overflow_err,
  output logic [15:0]                         pkt_count
);

  localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int OCC_W   = $clog2(BUFFER_DEPTH + 1);
  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;

  // Each slot stores {payload, destination, tail flag}.
  logic [ENTRY_W-1:0] mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               full;
  logic               pop;
  logic               push;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUFFER_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // out_valid comes only from registered occupancy, so a flit pushed in
  // cycle t is first visible in t+1 and send_in never reaches out_valid.
  assign full      = (occupancy == OCC_W'(BUFFER_DEPTH));
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a flit when the head leaves the same cycle.
  assign push      = send_in && (!full || pop);

  assign {out_data, out_dest, out_last} = mem[rd_ptr];

  // Slot storage: contents are don't-care until written, so no reset.
  always_ff @(posedge clk_noc) begin
    if (push) begin
      mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Input-side packet tracking: open on a body/head flit, close on a tail.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      in_packet <= 1'b0;
    end else if (push) begin
      in_packet <= !is_tail_in;
    end
  end

  // Sticky drop flag; only reset clears it.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (send_in && !push) begin
      overflow_err <= 1'b1;
    end
  end

  // Delivered-packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (pop && out_last) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

  // Credit return: one pulse per pop, either registered or combinational.
  if (CREDIT_REG != 0) begin : g_credit_reg
    logic credit_q;

    // Delay each pop by one cycle; consecutive pops give consecutive pulses.
    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
        credit_q <= 1'b0;
      end else begin
        credit_q <= pop;
      end
    end

    assign credit_out = credit_q;
  end else begin : g_credit_comb
    assign credit_out = pop;
  end

endmodule

// File: tb/tb_noc_link_credit_rx.sv
// Directed bench for noc_link_credit_rx (BUFFER_DEPTH = 2, CREDIT_REG = 1).
module tb_noc_link_credit_rx;

  localparam int FW    = 128;
  localparam int DW    = 6;
  localparam int DEPTH = 2;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              clk_noc;
  logic              rst_n;
  logic [FW-1:0]     data_in;
  logic [DW-1:0]     dest_in;
  logic              is_tail_in;
  logic              send_in;
  logic              credit_out;
  logic              out_valid;
  logic              out_ready;
  logic [FW-1:0]     out_data;
  logic [DW-1:0]     out_dest;
  logic              out_last;
  logic [OCC_W-1:0]  occupancy;
  logic              in_packet;
  logic              overflow_err;
  logic [15:0]       pkt_count;

  int checks;
  int failures;
  int credit_cnt;

  noc_link_credit_rx #(
    .FLIT_WIDTH  (FW),
    .DEST_WIDTH  (DW),
    .BUFFER_DEPTH(DEPTH),
    .CREDIT_REG  (1)
  ) dut (
    .clk_noc     (clk_noc),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .dest_in     (dest_in),
    .is_tail_in  (is_tail_in),
    .send_in     (send_in),
    .credit_out  (credit_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_dest    (out_dest),
    .out_last    (out_last),
    .occupancy   (occupancy),
    .in_packet   (in_packet),
    .overflow_err(overflow_err),
    .pkt_count   (pkt_count)
  );

  // Clock / reset block
  initial begin
    clk_noc = 1'b0;
    forever #5 clk_noc = ~clk_noc;
  end

  // Credit pulses counted mid-cycle, away from the active edge.
  always @(negedge clk_noc) begin
    if (credit_out === 1'b1) credit_cnt++;
  end

  // Advance one clock; inputs set before the call are sampled at that edge.
  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic idle_inputs();
    send_in    = 1'b0;
    data_in    = '0;
    dest_in    = '0;
    is_tail_in = 1'b0;
    out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push_flit(input logic [FW-1:0] d, input logic [DW-1:0] de, input logic tl);
    send_in    = 1'b1;
    data_in    = d;
    dest_in    = de;
    is_tail_in = tl;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (occupancy !== '0 || out_valid !== 1'b0 || credit_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_flow occ=%0d valid=%b credit=%b want 0/0/0", occupancy, out_valid, credit_out);
    end
    checks++;
    if (in_packet !== 1'b0 || overflow_err !== 1'b0 || pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_status in_packet=%b ovf=%b pkt=%0d want 0/0/0", in_packet, overflow_err, pkt_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [FW-1:0] pat;
    int c0;
    pat = {16{8'hA5}};
    do_reset();
    c0 = credit_cnt;
    push_flit(pat, 6'h05, 1'b1);
    out_ready = 1'b1;
    step();
    send_in = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== pat || out_dest !== 6'h05 || out_last !== 1'b1) begin
      failures++;
      $display("FAIL single_head valid=%b data=%h dest=%h last=%b want 1/%h/05/1", out_valid, out_data, out_dest, out_last, pat);
    end
    checks++;
    if (occupancy !== 2'd1 || credit_out !== 1'b0) begin
      failures++;
      $display("FAIL single_t1 occ=%0d credit=%b want 1/0", occupancy, credit_out);
    end
    step();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || credit_out !== 1'b1 || pkt_count !== 16'd1) begin
      failures++;
      $display("FAIL single_t2 occ=%0d valid=%b credit=%b pkt=%0d want 0/0/1/1", occupancy, out_valid, credit_out, pkt_count);
    end
    out_ready = 1'b0;
    step();
    checks++;
    if (credit_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL single_credits got=%0d want 1", credit_cnt - c0);
    end
  endtask

  task automatic test_overflow();
    int c0;
    do_reset();
    c0 = credit_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_flit(FW'(i), DW'(i), 1'b1);
      step();
    end
    send_in = 1'b0;
    step();
    checks++;
    if (occupancy !== 2'd2 || overflow_err !== 1'b1 || out_data !== FW'(0)) begin
      failures++;
      $display("FAIL ovf_full occ=%0d ovf=%b head=%0d want 2/1/0", occupancy, overflow_err, out_data);
    end
    checks++;
    if (credit_cnt - c0 !== 0) begin
      failures++;
      $display("FAIL ovf_drop_credit got=%0d want 0", credit_cnt - c0);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== FW'(1) || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL ovf_second valid=%b head=%0d occ=%0d want 1/1/1", out_valid, out_data, occupancy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      failures++;
      $display("FAIL ovf_drain valid=%b occ=%0d want 0/0", out_valid, occupancy);
    end
    step();
    step();
    checks++;
    if (credit_cnt - c0 !== 2 || overflow_err !== 1'b1 || pkt_count !== 16'd2) begin
      failures++;
      $display("FAIL ovf_credits credits=%0d ovf=%b pkt=%0d want 2/1/2", credit_cnt - c0, overflow_err, pkt_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_push_pop_full();
    int c0;
    do_reset();
    c0 = credit_cnt;
    push_flit(FW'(10), 6'h0A, 1'b1);
    step();
    push_flit(FW'(11), 6'h0B, 1'b1);
    step();
    push_flit(FW'(12), 6'h0C, 1'b1);
    out_ready = 1'b1;
    step();
    send_in   = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || overflow_err !== 1'b0 || out_data !== FW'(11) || out_dest !== 6'h0B) begin
      failures++;
      $display("FAIL pp_full occ=%0d ovf=%b head=%0d dest=%h want 2/0/11/0b", occupancy, overflow_err, out_data, out_dest);
    end
    step();
    checks++;
    if (credit_cnt - c0 !== 1) begin
      failures++;
      $display("FAIL pp_credit got=%0d want 1", credit_cnt - c0);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== FW'(12) || out_dest !== 6'h0C || occupancy !== 2'd1) begin
      failures++;
      $display("FAIL pp_newflit head=%0d dest=%h occ=%0d want 12/0c/1", out_data, out_dest, occupancy);
    end
    step();
    out_ready = 1'b0;
    step();
    checks++;
    if (credit_cnt - c0 !== 3 || pkt_count !== 16'd3 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL pp_drain credits=%0d pkt=%0d ovf=%b want 3/3/0", credit_cnt - c0, pkt_count, overflow_err);
    end
  endtask

  task automatic test_packet_stall();
    // Expected state after each edge; out_ready toggles 0,1,0,1,...
    int exp_occ  [8] = '{1, 1, 2, 2, 2, 1, 1, 0};
    int exp_head [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int exp_inpk [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
    int c0;
    do_reset();
    c0 = credit_cnt;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        push_flit(FW'(20 + k), DW'(k), (k == 3));
      end else begin
        send_in = 1'b0;
      end
      out_ready = (k % 2 == 1);
      step();
      checks++;
      if (occupancy !== OCC_W'(exp_occ[k]) || in_packet !== exp_inpk[k][0]) begin
        failures++;
        $display("FAIL pkt_state k=%0d occ=%0d inpk=%b want %0d/%0d", k, occupancy, in_packet, exp_occ[k], exp_inpk[k]);
      end
      if (exp_occ[k] != 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== FW'(20 + exp_head[k]) || out_last !== (exp_head[k] == 3)) begin
          failures++;
          $display("FAIL pkt_head k=%0d valid=%b data=%0d last=%b want 1/%0d/%0d", k, out_valid, out_data, out_last, 20 + exp_head[k], exp_head[k] == 3);
        end
      end
    end
    out_ready = 1'b0;
    step();
    checks++;
    if (credit_cnt - c0 !== 4 || pkt_count !== 16'd1 || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL pkt_totals credits=%0d pkt=%0d ovf=%b want 4/1/0", credit_cnt - c0, pkt_count, overflow_err);
    end
  endtask

  task automatic test_pkt_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      push_flit(FW'(i), DW'(i), 1'b1);
      step();
    end
    send_in = 1'b0;
    step();
    step();
    checks++;
    if (pkt_count !== 16'hFFFF || overflow_err !== 1'b0) begin
      failures++;
      $display("FAIL wrap_preload pkt=%h ovf=%b want ffff/0", pkt_count, overflow_err);
    end
    push_flit(FW'(7), 6'h07, 1'b1);
    step();
    send_in = 1'b0;
    step();
    step();
    checks++;
    if (pkt_count !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_rollover pkt=%h want 0000", pkt_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int c0;
    do_reset();
    out_ready = 1'b0;
    push_flit(FW'(30), 6'h01, 1'b0);
    step();
    push_flit(FW'(31), 6'h01, 1'b0);
    step();
    push_flit(FW'(32), 6'h01, 1'b0);
    step();
    send_in = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || in_packet !== 1'b1 || overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre occ=%0d inpk=%b ovf=%b want 2/1/1", occupancy, in_packet, overflow_err);
    end
    c0 = credit_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (occupancy !== '0 || out_valid !== 1'b0 || in_packet !== 1'b0 || overflow_err !== 1'b0 || credit_out !== 1'b0 || pkt_count !== 16'd0) begin
      failures++;
      $display("FAIL arst_immediate occ=%0d valid=%b inpk=%b ovf=%b credit=%b pkt=%0d want all 0", occupancy, out_valid, in_packet, overflow_err, credit_out, pkt_count);
    end
    step();
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (credit_cnt - c0 !== 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL arst_no_credit credits=%0d valid=%b want 0/0", credit_cnt - c0, out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    credit_cnt = 0;
    rst_n      = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_overflow();
    test_push_pop_full();
    test_packet_stall();
    test_pkt_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
